// File: rtl/rename_allocator.sv
// rename_allocator
// Dispatch-side rename stage. Accepts up to N in-order instructions per cycle,
// hands out physical destinations from the free list and renames sources through
// the speculative map, including bypass between lanes of the same group. It also
// keeps a retirement map, which is copied back into the speculative map on a
// mispredict.
//
// Ports:
//   clock, reset          clock; synchronous active-high reset (maps -> identity)
//   dispatch_valid        lane k holds an instruction (contiguous run from lane 0)
//   dest_valid            lane k writes a destination
//   dest_arch, src1_arch, src2_arch   per-lane architectural indices (N x AB)
//   fl_num_available      registers offered by the free list this cycle
//   fl_regs_to_use        offered registers, slot 0 in the low bits (N x PB)
//   fl_num_requested      registers consumed this cycle
//   num_dispatched        lanes accepted this cycle (lanes 0..num_dispatched-1)
//   new_dest_phys, old_dest_phys, src1_phys, src2_phys   per-lane results (N x PB)
//   retire_valid, retire_arch, retire_phys   retirement-map writes
//   mispredict            squash; restore speculative map from retirement map
module rename_allocator #(
  parameter int N         = 3,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  localparam int AB = $clog2(ARCH_REGS),
  localparam int PB = $clog2(PHYS_REGS),
  localparam int CB = $clog2(N + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    dispatch_valid,
  input  logic [N-1:0]    dest_valid,
  input  logic [N*AB-1:0] dest_arch,
  input  logic [N*AB-1:0] src1_arch,
  input  logic [N*AB-1:0] src2_arch,
  input  logic [CB-1:0]   fl_num_available,
  input  logic [N*PB-1:0] fl_regs_to_use,
  output logic [CB-1:0]   fl_num_requested,
  output logic [CB-1:0]   num_dispatched,
  output logic [N*PB-1:0] new_dest_phys,
  output logic [N*PB-1:0] old_dest_phys,
  output logic [N*PB-1:0] src1_phys,
  output logic [N*PB-1:0] src2_phys,
  input  logic [N-1:0]    retire_valid,
  input  logic [N*AB-1:0] retire_arch,
  input  logic [N*PB-1:0] retire_phys,
  input  logic            mispredict
);

  logic [PB-1:0] spec_map_reg    [ARCH_REGS];
  logic [PB-1:0] spec_map_next   [ARCH_REGS];
  logic [PB-1:0] retire_map_reg  [ARCH_REGS];
  logic [PB-1:0] retire_map_next [ARCH_REGS];

  logic [AB-1:0] dest_arch_lane   [N];
  logic [AB-1:0] src1_arch_lane   [N];
  logic [AB-1:0] src2_arch_lane   [N];
  logic [AB-1:0] retire_arch_lane [N];
  logic [PB-1:0] retire_phys_lane [N];
  logic [PB-1:0] fl_reg_lane      [N];
  logic [PB-1:0] new_lane         [N];
  logic [PB-1:0] old_lane         [N];
  logic [PB-1:0] src1_lane        [N];
  logic [PB-1:0] src2_lane        [N];
  logic [CB-1:0] slot_lane        [N];

  logic [N-1:0]  real_dest;
  logic [N-1:0]  accepted;
  logic [N-1:0]  writes_dest;
  logic [CB-1:0] used_cnt;
  logic [CB-1:0] disp_cnt;
  logic [CB:0]   need;
  logic          blocked;

  // Unpack lane fields and pack results.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign dest_arch_lane[gi]   = dest_arch[gi*AB +: AB];
      assign src1_arch_lane[gi]   = src1_arch[gi*AB +: AB];
      assign src2_arch_lane[gi]   = src2_arch[gi*AB +: AB];
      assign retire_arch_lane[gi] = retire_arch[gi*AB +: AB];
      assign retire_phys_lane[gi] = retire_phys[gi*PB +: PB];
      assign fl_reg_lane[gi]      = fl_regs_to_use[gi*PB +: PB];
      // A write to x0 is no write at all: it takes no register.
      assign real_dest[gi]        = dest_valid[gi] && (dest_arch_lane[gi] != '0);
      assign new_dest_phys[gi*PB +: PB] = new_lane[gi];
      assign old_dest_phys[gi*PB +: PB] = old_lane[gi];
      assign src1_phys[gi*PB +: PB]     = src1_lane[gi];
      assign src2_phys[gi*PB +: PB]     = src2_lane[gi];
    end
  endgenerate

  // Acceptance: walk lanes in order; the first lane that is not valid or cannot
  // get a register blocks itself and everything after it. slot_lane[k] is the
  // free-list slot a real-destination lane k would take.
  always_comb begin
    accepted = '0;
    used_cnt = '0;
    disp_cnt = '0;
    need     = '0;
    blocked  = reset | mispredict;
    for (int k = 0; k < N; k++) begin
      slot_lane[k] = used_cnt;
      need = {1'b0, used_cnt} + {{CB{1'b0}}, real_dest[k]};
      if (!blocked && dispatch_valid[k] && (need <= {1'b0, fl_num_available})) begin
        accepted[k] = 1'b1;
        disp_cnt    = disp_cnt + CB'(1);
        if (real_dest[k]) begin
          used_cnt = used_cnt + CB'(1);
        end
      end else begin
        blocked = 1'b1;
      end
    end
    fl_num_requested = used_cnt;
    num_dispatched   = disp_cnt;
  end

  assign writes_dest = accepted & real_dest;

  // Rename: start from the speculative map, then let each earlier writing lane
  // in ascending order override, so the youngest earlier writer wins. x0 is
  // never written, so its map entry stays 0 and sources of x0 read 0.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      new_lane[k] = writes_dest[k] ? fl_reg_lane[slot_lane[k]] : '0;
    end
    for (int k = 0; k < N; k++) begin
      old_lane[k]  = spec_map_reg[dest_arch_lane[k]];
      src1_lane[k] = spec_map_reg[src1_arch_lane[k]];
      src2_lane[k] = spec_map_reg[src2_arch_lane[k]];
      for (int j = 0; j < k; j++) begin
        if (writes_dest[j] && (dest_arch_lane[j] == dest_arch_lane[k])) old_lane[k]  = new_lane[j];
        if (writes_dest[j] && (dest_arch_lane[j] == src1_arch_lane[k])) src1_lane[k] = new_lane[j];
        if (writes_dest[j] && (dest_arch_lane[j] == src2_arch_lane[k])) src2_lane[k] = new_lane[j];
      end
      if (!writes_dest[k]) old_lane[k] = '0;
      if (!accepted[k]) begin
        src1_lane[k] = '0;
        src2_lane[k] = '0;
      end
    end
  end

  // Map updates. Later lanes are applied last so the highest lane wins. A
  // mispredict restores from the retirement map including this cycle's retires.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      retire_map_next[i] = retire_map_reg[i];
    end
    for (int k = 0; k < N; k++) begin
      if (retire_valid[k] && (retire_arch_lane[k] != '0)) begin
        retire_map_next[retire_arch_lane[k]] = retire_phys_lane[k];
      end
    end
    for (int i = 0; i < ARCH_REGS; i++) begin
      spec_map_next[i] = mispredict ? retire_map_next[i] : spec_map_reg[i];
    end
    if (!mispredict) begin
      for (int k = 0; k < N; k++) begin
        if (writes_dest[k]) begin
          spec_map_next[dest_arch_lane[k]] = new_lane[k];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map_reg[i]   <= PB'(i);
        retire_map_reg[i] <= PB'(i);
      end
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map_reg[i]   <= spec_map_next[i];
        retire_map_reg[i] <= retire_map_next[i];
      end
    end
  end

endmodule

// File: tb/tb_rename_allocator.sv
// tb_rename_allocator
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model: each group is renamed by walking lanes in order against a
// scratch copy of the speculative map that earlier lanes update as they go.
module tb_rename_allocator;
  localparam int N  = 3;
  localparam int AB = 5;
  localparam int PB = 6;
  localparam int CB = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    dispatch_valid, dest_valid;
  logic [N*AB-1:0] dest_arch, src1_arch, src2_arch;
  logic [CB-1:0]   fl_num_available;
  logic [N*PB-1:0] fl_regs_to_use;
  logic [CB-1:0]   fl_num_requested, num_dispatched;
  logic [N*PB-1:0] new_dest_phys, old_dest_phys, src1_phys, src2_phys;
  logic [N-1:0]    retire_valid;
  logic [N*AB-1:0] retire_arch;
  logic [N*PB-1:0] retire_phys;
  logic            mispredict;

  rename_allocator dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dest_valid(dest_valid),
    .dest_arch(dest_arch), .src1_arch(src1_arch), .src2_arch(src2_arch),
    .fl_num_available(fl_num_available), .fl_regs_to_use(fl_regs_to_use),
    .fl_num_requested(fl_num_requested), .num_dispatched(num_dispatched),
    .new_dest_phys(new_dest_phys), .old_dest_phys(old_dest_phys),
    .src1_phys(src1_phys), .src2_phys(src2_phys),
    .retire_valid(retire_valid), .retire_arch(retire_arch), .retire_phys(retire_phys),
    .mispredict(mispredict)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference state
  int spec_m [32];
  int ret_m  [32];
  int tmp_m  [32];
  int e_nd, e_req;
  int e_new [N];
  int e_old [N];
  int e_s1  [N];
  int e_s2  [N];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic clear_inputs();
    dispatch_valid = '0; dest_valid = '0;
    dest_arch = '0; src1_arch = '0; src2_arch = '0;
    fl_num_available = '0; fl_regs_to_use = '0;
    retire_valid = '0; retire_arch = '0; retire_phys = '0;
    mispredict = 1'b0;
  endtask

  task automatic set_lane(int k, bit dv, bit dval, int d, int s1, int s2);
    dispatch_valid[k] = dv;
    dest_valid[k]     = dval;
    dest_arch[k*AB +: AB] = AB'(d);
    src1_arch[k*AB +: AB] = AB'(s1);
    src2_arch[k*AB +: AB] = AB'(s2);
  endtask

  task automatic set_fl(int avail, int r0, int r1, int r2);
    fl_num_available = CB'(avail);
    fl_regs_to_use[0*PB +: PB] = PB'(r0);
    fl_regs_to_use[1*PB +: PB] = PB'(r1);
    fl_regs_to_use[2*PB +: PB] = PB'(r2);
  endtask

  task automatic set_retire(int k, int a, int p);
    retire_valid[k] = 1'b1;
    retire_arch[k*AB +: AB] = AB'(a);
    retire_phys[k*PB +: PB] = PB'(p);
  endtask

  task automatic model_eval();
    e_nd = 0; e_req = 0;
    for (int k = 0; k < N; k++) begin
      e_new[k] = 0; e_old[k] = 0; e_s1[k] = 0; e_s2[k] = 0;
    end
    tmp_m = spec_m;
    if (!reset && !mispredict) begin
      for (int k = 0; k < N; k++) begin
        int d, a, b, r;
        if (!dispatch_valid[k]) break;
        d = int'(dest_arch[k*AB +: AB]);
        a = int'(src1_arch[k*AB +: AB]);
        b = int'(src2_arch[k*AB +: AB]);
        r = (dest_valid[k] && d != 0) ? 1 : 0;
        if (e_req + r > int'(fl_num_available)) break;
        e_s1[k] = (a == 0) ? 0 : tmp_m[a];
        e_s2[k] = (b == 0) ? 0 : tmp_m[b];
        if (r == 1) begin
          e_old[k] = tmp_m[d];
          e_new[k] = int'(fl_regs_to_use[e_req*PB +: PB]);
          tmp_m[d] = e_new[k];
          e_req++;
        end
        e_nd++;
      end
    end
  endtask

  task automatic model_commit();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        spec_m[i] = i;
        ret_m[i]  = i;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (retire_valid[k] && retire_arch[k*AB +: AB] != 0)
          ret_m[int'(retire_arch[k*AB +: AB])] = int'(retire_phys[k*PB +: PB]);
      end
      if (mispredict) spec_m = ret_m;
      else            spec_m = tmp_m;
    end
  endtask

  // Inputs are set just after a falling edge; check, clock, update model.
  task automatic step();
    #1;
    model_eval();
    check("num_dispatched", 32'(num_dispatched), e_nd);
    check("fl_num_requested", 32'(fl_num_requested), e_req);
    for (int k = 0; k < N; k++) begin
      check($sformatf("new_dest[%0d]", k), 32'(new_dest_phys[k*PB +: PB]), e_new[k]);
      check($sformatf("old_dest[%0d]", k), 32'(old_dest_phys[k*PB +: PB]), e_old[k]);
      check($sformatf("src1[%0d]", k), 32'(src1_phys[k*PB +: PB]), e_s1[k]);
      check($sformatf("src2[%0d]", k), 32'(src2_phys[k*PB +: PB]), e_s2[k]);
    end
    $display("cycle %0d rst=%0d mp=%0d dv=%b avail=%0d -> nd=%0d req=%0d",
             cycle, reset, mispredict, dispatch_valid, fl_num_available,
             num_dispatched, fl_num_requested);
    @(posedge clock);
    model_commit();
    @(negedge clock);
    cycle++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      spec_m[i] = i;
      ret_m[i]  = i;
    end
    clear_inputs();
    @(negedge clock);

    // Reset: outputs held at 0 even with work offered
    reset = 1'b1;
    set_fl(3, 10, 11, 12);
    set_lane(0, 1, 1, 4, 4, 4);
    step();
    step();
    reset = 1'b0;

    // Basic allocation
    clear_inputs();
    set_fl(3, 40, 41, 42);
    set_lane(0, 1, 1, 1, 0, 0);
    set_lane(1, 1, 1, 2, 0, 0);
    set_lane(2, 1, 1, 3, 0, 0);
    #1;
    check("basic nd", 32'(num_dispatched), 3);
    check("basic req", 32'(fl_num_requested), 3);
    check("basic new0", 32'(new_dest_phys[0 +: PB]), 40);
    check("basic new2", 32'(new_dest_phys[2*PB +: PB]), 42);
    check("basic old1", 32'(old_dest_phys[PB +: PB]), 2);
    step();
    clear_inputs();
    set_lane(0, 1, 0, 0, 2, 0);
    #1;
    check("x2 renamed", 32'(src1_phys[0 +: PB]), 41);
    step();

    // Intra-group chain
    clear_inputs();
    set_fl(3, 50, 51, 52);
    set_lane(0, 1, 1, 5, 5, 0);
    set_lane(1, 1, 1, 6, 5, 0);
    set_lane(2, 1, 1, 5, 6, 0);
    #1;
    check("chain src1_0", 32'(src1_phys[0 +: PB]), 5);
    check("chain src1_1", 32'(src1_phys[PB +: PB]), 50);
    check("chain src1_2", 32'(src1_phys[2*PB +: PB]), 51);
    check("chain old_2", 32'(old_dest_phys[2*PB +: PB]), 50);
    step();
    clear_inputs();
    set_lane(0, 1, 0, 0, 5, 6);
    #1;
    check("chain x5", 32'(src1_phys[0 +: PB]), 52);
    step();

    // Stall on free-list shortage
    clear_inputs();
    set_fl(1, 20, 21, 22);
    set_lane(0, 1, 1, 10, 1, 2);
    set_lane(1, 1, 1, 11, 3, 4);
    set_lane(2, 1, 1, 12, 5, 6);
    #1;
    check("stall nd", 32'(num_dispatched), 1);
    check("stall req", 32'(fl_num_requested), 1);
    step();
    dest_valid[1] = 1'b0;
    #1;
    check("stall nd nodest", 32'(num_dispatched), 2);
    step();

    // x0 handling
    clear_inputs();
    set_fl(3, 30, 31, 32);
    set_lane(0, 1, 1, 0, 0, 0);
    set_lane(1, 1, 1, 0, 0, 0);
    #1;
    check("x0 req", 32'(fl_num_requested), 0);
    check("x0 new", 32'(new_dest_phys[0 +: PB]), 0);
    step();
    clear_inputs();
    set_lane(0, 1, 0, 0, 0, 0);
    #1;
    check("x0 src", 32'(src1_phys[0 +: PB]), 0);
    step();

    // Mispredict with simultaneous dispatch and retire
    clear_inputs();
    set_fl(1, 60, 61, 62);
    set_lane(0, 1, 1, 7, 0, 0);
    set_retire(0, 7, 45);
    mispredict = 1'b1;
    #1;
    check("mp nd", 32'(num_dispatched), 0);
    step();
    clear_inputs();
    set_lane(0, 1, 0, 0, 7, 0);
    #1;
    check("mp x7", 32'(src1_phys[0 +: PB]), 45);
    step();

    // Retire collision, no same-cycle bypass, then restore
    clear_inputs();
    set_retire(0, 9, 33);
    set_retire(1, 9, 34);
    set_lane(0, 1, 0, 0, 9, 0);
    #1;
    check("retire nobypass", 32'(src1_phys[0 +: PB]), 9);
    step();
    clear_inputs();
    mispredict = 1'b1;
    step();
    clear_inputs();
    set_lane(0, 1, 0, 0, 9, 0);
    #1;
    check("retire x9", 32'(src1_phys[0 +: PB]), 34);
    step();

    // Randomized traffic
    for (int t = 0; t < 1500; t++) begin
      int rc;
      clear_inputs();
      reset      = ($urandom_range(0, 99) == 0);
      mispredict = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < N; k++) begin
        bit narrow;
        narrow = ($urandom_range(0, 1) == 1);
        set_lane(k, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                 narrow ? $urandom_range(0, 7) : $urandom_range(0, 31),
                 narrow ? $urandom_range(0, 7) : $urandom_range(0, 31),
                 narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
      end
      set_fl($urandom_range(0, 3), $urandom_range(1, 63), $urandom_range(1, 63),
             $urandom_range(1, 63));
      rc = $urandom_range(0, 3);
      for (int k = 0; k < rc; k++) begin
        set_retire(k, $urandom_range(0, 7), $urandom_range(1, 63));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_allocator.md
# rename_allocator

Dispatch-side consumer of the physical-register free list. Each cycle it accepts up to N in-order instructions from decode and takes fresh physical destinations from the free list. It renames their sources through a speculative map table, with intra-group bypass, and reports old destinations to the ROB. It also maintains a retirement map table and restores the speculative map from it on a branch mispredict.

## Interface
- N, 3, dispatch/retire width
- ARCH_REGS, 32, architectural registers; index width AB = $clog2(ARCH_REGS)
- PHYS_REGS, 64, physical registers; index width PB = $clog2(PHYS_REGS)
- CB, $clog2(N+1), width of lane counts

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- dispatch_valid  in  N  lane k holds an instruction
- dest_valid  in  N  lane k writes a destination
- dest_arch, src1_arch, src2_arch  in  N×AB  architectural indices per lane
- fl_num_available  in  CB  free registers offered by the free list this cycle
- fl_regs_to_use  in  N×PB  offered registers, slot 0 first
- fl_num_requested  out  CB  registers consumed this cycle
- num_dispatched  out  CB  lanes accepted this cycle (lanes 0..num_dispatched-1)
- new_dest_phys, old_dest_phys  out  N×PB  per accepted lane
- src1_phys, src2_phys  out  N×PB  per accepted lane
- retire_valid  in  N  lane k retires this cycle (in order, contiguous from 0)
- retire_arch  in  N×AB  retiring destination architectural index
- retire_phys  in  N×PB  retiring destination physical index
- mispredict  in  1  squash; restore speculative map

## Operation
- State: spec_map[ARCH_REGS] and retire_map[ARCH_REGS], each PB wide.
- Arch reg 0 always maps to phys 0 and is never renamed. A dest_valid lane with dest_arch=0 is treated as having no destination and consumes no register.
- Effective lanes: only the contiguous run of dispatch_valid starting at lane 0 counts. Lanes after the first 0 are ignored.
- Acceptance: lane k is accepted iff every earlier lane was accepted and the count of real-destination lanes in 0..k is ≤ fl_num_available. The first lane that cannot get a register stalls itself and every later lane.
- The j-th accepted real-destination lane, counting from 0, receives fl_regs_to_use[j] as new_dest_phys.
- fl_num_requested = count of accepted real-destination lanes. It never exceeds fl_num_available.
- Sources and old destinations take the new_dest_phys of the youngest earlier accepted lane in the same group that writes the same arch reg. Otherwise they take spec_map. Source arch 0 yields phys 0.
- Outputs for non-accepted lanes and for lanes without a real destination are 0.
- spec_map update: accepted real-destination lanes write new_dest_phys. If several lanes write the same arch reg, the highest lane wins.
- retire_map update: lanes with retire_valid write retire_phys at retire_arch. The highest lane wins; arch 0 writes are ignored.
- Mispredict: num_dispatched=0 and fl_num_requested=0 that cycle. At the next edge, spec_map becomes retire_map with this cycle's retire writes applied. Mispredict has priority over dispatch writes; retires are still performed.
- Reset: spec_map[i] = retire_map[i] = i. Reset has priority over mispredict, dispatch and retire.

## Timing
- Rename is combinational. All outputs are valid in the same cycle as the inputs.
- Map writes become visible on the next cycle's outputs. There is no same-cycle bypass from retire into rename.
- While reset is high, every output is 0. In the first cycle after reset, a source arch i renames to phys i.
- Reset asserted mid-stream discards all pending map updates at that edge.
- fl_num_available=0: num_dispatched counts only the leading lanes that have no real destination.

## Test plan
- After reset with N=3 and fl_num_available=3 offering {40,41,42}, lanes write x1, x2, x3 -> num_dispatched=3, fl_num_requested=3, new={40,41,42}, old={1,2,3}. Next cycle a source x2 renames to 41.
- Intra-group chain: lane0 x5<-x5, lane1 x6<-x5, lane2 x5<-x6, offering {50,51,52} -> src1={5,50,51}, old_dest={5,6,50}. Next cycle x5 maps to 52.
- Stall: fl_num_available=1 with three real-destination lanes -> num_dispatched=1, fl_num_requested=1. With lane1 having no destination, num_dispatched=2.
- x0 handling: a lane writes x0 and another reads x0 -> no register consumed, new_dest=0, src_phys=0, spec_map[0] stays 0.
- Mispredict: rename x7->60 and retire x7->45 in the same cycle as mispredict -> num_dispatched=0 that cycle. Next cycle x7 renames to 45.
- Same-arch collisions: two retire lanes write x9 (33, then 34) -> retire_map[9]=34. Verify by mispredict, after which x9 renames to 34.
